// File: rtl/lc3_pkg.sv
// lc3_pkg: shared microsequencer constants, control-word field positions and COND encodings.
package lc3_pkg;
  localparam int UPC_W = 6;
  localparam int UI_W = 49;
  localparam int IRD_BIT = 48;
  localparam int COND_HI = 47;
  localparam int COND_LO = 45;
  localparam int J_HI = 44;
  localparam int J_LO = 39;
  localparam logic [UPC_W-1:0] FETCH_STATE_DEF = 6'd18;
  typedef enum logic [2:0] {
    COND_UNC  = 3'b000,
    COND_RDY  = 3'b001,
    COND_BEN  = 3'b010,
    COND_ADDR = 3'b011,
    COND_PRIV = 3'b100,
    COND_INT  = 3'b101
  } cond_e;
endpackage

// File: rtl/next_addr_logic.sv
// next_addr_logic: combinational next-uPC selection from IRD/COND/J and datapath status.
module next_addr_logic
  import lc3_pkg::*;
(
  input  logic [UI_W-1:0]  i_u_instruction,
  input  logic [15:0]      i_ir,
  input  logic             i_ben,
  input  logic             i_r,
  input  logic             i_psr15,
  input  logic             i_intr,
  output logic [UPC_W-1:0] o_next
);
  logic [2:0]       w_cond;
  logic [UPC_W-1:0] w_j;
  logic [UPC_W-1:0] w_or;
  logic             w_unused;
  assign w_cond = i_u_instruction[COND_HI:COND_LO];
  assign w_j = i_u_instruction[J_HI:J_LO];
  assign w_unused = ^{i_u_instruction[J_LO-1:0], i_ir[10:0]};
  // COND 110/111 fall through to no modifier, same as unconditional
  always_comb begin
    w_or = (w_cond == COND_RDY)  ? {4'b0, i_r, 1'b0} :
           (w_cond == COND_BEN)  ? {3'b0, i_ben, 2'b0} :
           (w_cond == COND_ADDR) ? {5'b0, i_ir[11]} :
           (w_cond == COND_PRIV) ? {2'b0, i_psr15, 3'b0} :
           (w_cond == COND_INT)  ? {1'b0, i_intr, 4'b0} : '0;
    o_next = i_u_instruction[IRD_BIT] ? {2'b00, i_ir[15:12]} : (w_j | w_or);
  end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: LC-3 uPC register, BEN, instruction-fetch counter and memory-wait watchdog.
module micro_sequencer
  import lc3_pkg::*;
#(
  parameter int               MEM_TIMEOUT = 64,
  parameter logic [UPC_W-1:0] FETCH_STATE = FETCH_STATE_DEF,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [UI_W-1:0]  u_instruction,
  input  logic [15:0]      ir,
  input  logic             ld_ben,
  input  logic             n,
  input  logic             z,
  input  logic             p,
  input  logic             r,
  input  logic             psr15,
  input  logic             intr,
  output logic [UPC_W-1:0] upc,
  output logic             ben,
  output logic [CNT_W-1:0] instr_count,
  output logic             mem_timeout
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);
  logic [UPC_W-1:0] r_upc;
  logic             r_ben;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic [WW-1:0]    r_wait_cnt;
  logic [UPC_W-1:0] w_next;
  logic             w_wait;
  logic             w_fetch_entry;
  next_addr_logic u_next (
    .i_u_instruction(u_instruction),
    .i_ir(ir),
    .i_ben(r_ben),
    .i_r(r),
    .i_psr15(psr15),
    .i_intr(intr),
    .o_next(w_next)
  );
  assign w_wait = !u_instruction[IRD_BIT] && (u_instruction[COND_HI:COND_LO] == COND_RDY) && !r;
  assign w_fetch_entry = (w_next == FETCH_STATE) && (r_upc != FETCH_STATE);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_upc <= FETCH_STATE;
      r_ben <= 1'b0;
      r_cnt <= '0;
      r_timeout <= 1'b0;
      r_wait_cnt <= '0;
    end else if (run) begin
      r_upc <= w_next;
      if (ld_ben) r_ben <= (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
      if (w_fetch_entry) r_cnt <= r_cnt + CNT_W'(1);
      // wait_cnt parks at LAST so the sticky flag needs no wider counter
      if (!w_wait) r_wait_cnt <= '0;
      else if (r_wait_cnt == LAST) r_timeout <= 1'b1;
      else r_wait_cnt <= r_wait_cnt + WW'(1);
    end
  end
  assign upc = r_upc;
  assign ben = r_ben;
  assign instr_count = r_cnt;
  assign mem_timeout = r_timeout;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vectors with hand-computed expectations for micro_sequencer.
module tb_micro_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b1;
  logic [48:0] u_instruction = '0;
  logic [15:0] ir = '0;
  logic        ld_ben = 1'b0, n = 1'b0, z = 1'b0, p = 1'b0;
  logic        r = 1'b0, psr15 = 1'b0, intr = 1'b0;
  logic [5:0]  upc;
  logic        ben;
  logic [15:0] instr_count;
  logic        mem_timeout;
  int n_cmp = 0;
  int n_bad = 0;
  micro_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .u_instruction(u_instruction), .ir(ir),
    .ld_ben(ld_ben), .n(n), .z(z), .p(p), .r(r), .psr15(psr15), .intr(intr),
    .upc(upc), .ben(ben), .instr_count(instr_count), .mem_timeout(mem_timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [48:0] uw(input logic ird, input logic [2:0] cond, input logic [5:0] j);
    return {ird, cond, j, 39'd0};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    u_instruction = uw(0, 3'd0, 6'd33);
    tick();
    tick();
    check("rst_upc", 32'(upc), 18);
    check("rst_ben", 32'(ben), 0);
    check("rst_cnt", 32'(instr_count), 0);
    check("rst_to", 32'(mem_timeout), 0);
    rst = 1'b0;
    tick();
    check("unc_33", 32'(upc), 33);
    check("unc_cnt", 32'(instr_count), 0);
    u_instruction = uw(0, 3'd0, 6'd32);
    tick();
    check("unc_32", 32'(upc), 32);
    u_instruction = uw(1, 3'd1, 6'd7);
    ir = 16'h1234;
    r = 1'b1;
    tick();
    check("ird_1", 32'(upc), 1);
    u_instruction = uw(0, 3'd0, 6'd32);
    tick();
    u_instruction = uw(1, 3'd0, 6'd0);
    ir = 16'hF000;
    tick();
    check("ird_15", 32'(upc), 15);
    u_instruction = uw(0, 3'd2, 6'd18);
    ld_ben = 1'b1;
    ir = 16'h0800;
    n = 1'b1;
    tick();
    check("br_old0_upc", 32'(upc), 18);
    check("br_old0_ben", 32'(ben), 1);
    check("cnt_1", 32'(instr_count), 1);
    ld_ben = 1'b0;
    tick();
    check("br_taken", 32'(upc), 22);
    check("br_ben_hold", 32'(ben), 1);
    ld_ben = 1'b1;
    ir = 16'h0000;
    tick();
    check("br_old1_upc", 32'(upc), 22);
    check("br_old1_ben", 32'(ben), 0);
    ld_ben = 1'b0;
    n = 1'b0;
    tick();
    check("br_not", 32'(upc), 18);
    check("cnt_2", 32'(instr_count), 2);
    u_instruction = uw(0, 3'd0, 6'd18);
    tick();
    check("self_loop_upc", 32'(upc), 18);
    check("self_loop_cnt", 32'(instr_count), 2);
    r = 1'b0;
    u_instruction = uw(0, 3'd0, 6'd33);
    tick();
    u_instruction = uw(0, 3'd1, 6'd33);
    repeat (63) tick();
    check("wait63_upc", 32'(upc), 33);
    check("wait63_to", 32'(mem_timeout), 0);
    tick();
    check("wait64_to", 32'(mem_timeout), 1);
    r = 1'b1;
    tick();
    check("ready_upc", 32'(upc), 35);
    check("ready_to", 32'(mem_timeout), 1);
    run = 1'b0;
    u_instruction = uw(0, 3'd0, 6'd18);
    repeat (3) tick();
    check("frz_upc", 32'(upc), 35);
    check("frz_cnt", 32'(instr_count), 2);
    run = 1'b1;
    tick();
    check("cnt_3_upc", 32'(upc), 18);
    check("cnt_3", 32'(instr_count), 3);
    r = 1'b0;
    u_instruction = uw(0, 3'd5, 6'd33);
    intr = 1'b1;
    tick();
    check("int_1", 32'(upc), 49);
    intr = 1'b0;
    tick();
    check("int_0", 32'(upc), 33);
    u_instruction = uw(0, 3'd4, 6'd32);
    psr15 = 1'b1;
    tick();
    check("priv_1", 32'(upc), 40);
    psr15 = 1'b0;
    u_instruction = uw(0, 3'd3, 6'd20);
    ir = 16'h0800;
    tick();
    check("addr_1", 32'(upc), 21);
    u_instruction = uw(0, 3'd6, 6'd33);
    r = 1'b1;
    intr = 1'b1;
    psr15 = 1'b1;
    tick();
    check("cond6", 32'(upc), 33);
    u_instruction = uw(0, 3'd0, 6'd32);
    tick();
    check("unc_no_or", 32'(upc), 32);
    r = 1'b0;
    intr = 1'b0;
    psr15 = 1'b0;
    u_instruction = uw(0, 3'd0, 6'd33);
    ld_ben = 1'b1;
    ir = 16'h0200;
    p = 1'b1;
    tick();
    check("ben_p", 32'(ben), 1);
    ld_ben = 1'b0;
    p = 1'b0;
    u_instruction = uw(0, 3'd1, 6'd33);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_upc", 32'(upc), 18);
    check("mid_rst_cnt", 32'(instr_count), 0);
    check("mid_rst_to", 32'(mem_timeout), 0);
    check("mid_rst_ben", 32'(ben), 0);
    rst = 1'b0;
    repeat (40) tick();
    u_instruction = uw(0, 3'd0, 6'd33);
    tick();
    u_instruction = uw(0, 3'd1, 6'd33);
    repeat (63) tick();
    check("rewait63_to", 32'(mem_timeout), 0);
    check("rewait63_upc", 32'(upc), 33);
    tick();
    check("rewait64_to", 32'(mem_timeout), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
